// File: rtl/apb_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_pkg : shared types for the multi-channel APB requester      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package apb_cmd_pkg;

  // Widest read data a response entry can carry; the top zero-extends prdata into it.
  localparam int RSP_DW = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0]        ch;
    logic [RSP_DW-1:0] rdata;
    logic              err;
    logic              tout;
  } rsp_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_cmd_rsp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_rsp_fifo : show-ahead synchronous FIFO for APB completions  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module apb_cmd_rsp_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             c_PW    = $clog2(DEPTH);
  localparam logic [c_PW:0]  c_DEPTH = (c_PW+1)'(DEPTH);

  T                r_mem [DEPTH];
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_PW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Empty pops are ignored; a push at full is only taken when a pop frees the slot.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != c_DEPTH) || w_pop);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

  assign pop_data = r_mem[r_rptr];
  assign full     = (r_count == c_DEPTH);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_master : round-robin multi-channel APB requester with       |
// | wait-state/timeout handling and a tagged response FIFO. Rev 1.0    |
// +--------------------------------------------------------------------+
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic [NCH-1:0]             cmd_valid,
  output logic [NCH-1:0]             cmd_ready,
  input  logic [NCH-1:0]             cmd_write,
  input  logic [NCH*AW-1:0]          cmd_addr,
  input  logic [NCH*DW-1:0]          cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ch_width(NCH)-1:0]   rsp_ch,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       rsp_err,
  output logic                       rsp_tout,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [AW-1:0]              paddr,
  output logic [DW-1:0]              pwdata,
  input  logic [DW-1:0]              prdata,
  input  logic                       pready,
  input  logic                       pslverr,
  output logic                       busy
);

  localparam int                        c_CHW   = ch_width(NCH);
  localparam int                        c_CNTW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNTW-1:0]         c_TMAX  = (TIMEOUT > 0) ? c_CNTW'(TIMEOUT - 1) : '0;
  localparam int                        c_QW    = $clog2(RSP_DEPTH) + 1;
  localparam logic [c_QW-1:0]           c_QDEP  = c_QW'(RSP_DEPTH);
  localparam logic [c_CHW:0]            c_NCH   = (c_CHW+1)'(NCH);

  state_e             r_state;
  logic [c_CHW-1:0]   r_rr_ptr;
  logic [c_CHW-1:0]   r_gnt;
  logic [c_CNTW-1:0]  r_cnt;

  logic [2*NCH-1:0]   w_rot;
  logic [c_CHW-1:0]   w_off;
  logic [c_CHW:0]     w_sum;
  logic [c_CHW:0]     w_wrap;
  logic [c_CHW-1:0]   w_gnt;
  logic [c_CHW-1:0]   w_rr_next;
  logic               w_issue;
  logic               w_space;
  logic               w_write;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_wdata;
  logic               w_tout;
  logic               w_push;
  rsp_t               w_push_data;
  rsp_t               w_head;
  logic               w_full;
  logic               w_empty;
  logic [c_QW-1:0]    w_count;

  // Rotate the requests so rr_ptr sits at bit 0; the lowest set bit is the grant offset.
  always_comb begin
    w_rot = {cmd_valid, cmd_valid} >> r_rr_ptr;
    w_off = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_CHW'(i);
    end
    w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_wrap = w_sum - c_NCH;
    w_gnt  = (w_sum >= c_NCH) ? w_wrap[c_CHW-1:0] : w_sum[c_CHW-1:0];
  end

  assign w_rr_next = (w_gnt == c_CHW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
  assign w_space   = (w_count < c_QDEP);
  assign w_issue   = (r_state == IDLE) && (cmd_valid != '0) && w_space;

  always_comb begin
    cmd_ready = '0;
    w_write   = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt == c_CHW'(c)) begin
        cmd_ready[c] = w_issue;
        w_write      = cmd_write[c];
        w_addr       = cmd_addr[c*AW +: AW];
        w_wdata      = cmd_wdata[c*DW +: DW];
      end
    end
  end

  // A ready slave on the last allowed cycle still completes normally.
  assign w_tout = (TIMEOUT > 0) && !pready && (r_cnt == c_TMAX);
  assign w_push = (r_state == ACCESS) && (pready || w_tout);

  always_comb begin
    w_push_data                 = '0;
    w_push_data.ch              = 8'(r_gnt);
    w_push_data.rdata[DW-1:0]   = (pready && !pwrite) ? prdata : '0;
    w_push_data.err             = pready ? pslverr : 1'b1;
    w_push_data.tout            = !pready;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_cnt    <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state  <= SETUP;
            r_gnt    <= w_gnt;
            r_rr_ptr <= w_rr_next;
            psel     <= 1'b1;
            pwrite   <= w_write;
            paddr    <= w_addr;
            pwdata   <= w_wdata;
            busy     <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready || w_tout) begin
            r_state <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  apb_cmd_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .T     (rsp_t)
  ) u_rsp_fifo (
    .pclk      (pclk),
    .preset    (preset),
    .push      (w_push && !w_full),
    .push_data (w_push_data),
    .pop       (rsp_ready),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign rsp_valid = !w_empty;
  assign rsp_ch    = w_head.ch[c_CHW-1:0];
  assign rsp_rdata = w_head.rdata[DW-1:0];
  assign rsp_err   = w_head.err;
  assign rsp_tout  = w_head.tout;

endmodule
`default_nettype wire
